fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the control decoder. It owns the PC and requests 16-bit instructions from instruction memory over a req/ack handshake. It holds each fetched instruction in a one-entry output register and presents its opcode field to the control unit. It absorbs downstream stalls with a one-entry skid buffer, and it handles branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

Parameters:
ADDR_W, 16, PC / instruction-memory byte-address width
INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, byte increment per instruction

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  instruction-memory request
imem_addr  out  ADDR_W  request address; stable while imem_req=1 and no ack
imem_ack  in  1  response valid this cycle; imem_rdata sampled at this edge
imem_rdata  in  INSTR_W  fetched instruction
stall  in  1  downstream cannot accept if_* this cycle
redirect  in  1  branch taken / jump; discard fetched work
redirect_pc  in  ADDR_W  new fetch address
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_instr  out  INSTR_W  registered instruction
if_pc  out  ADDR_W  address of if_instr
opCode  out  4  to control: if_valid ? if_instr[15:12] : 4'b0000

Behaviour:
- Reset: the block is synchronous to clk. rst=1 at an edge sets:
  - pc=RESET_PC, state=FETCH
  - if_valid=0, if_instr=0, if_pc=0, skid empty
  - imem_req is forced 0 while rst=1.
- Reset mid-operation: reset abandons any outstanding request. The memory must tolerate a dropped req.
- Consume: an instruction is consumed at an edge where if_valid=1 and stall=0. slot_free = ~if_valid | ~stall.
- Output register: if_valid/if_instr/if_pc change only on load, consume, redirect or reset. Contents are held while stalled.
- FETCH state:
  - imem_req=1, imem_addr=pc.
  - On ack with slot_free: load if_instr=imem_rdata and if_pc=pc; set if_valid=1; pc+=PC_INC; stay in FETCH.
  - On ack with no free slot: capture into skid (instr, pc); pc+=PC_INC; go to HOLD.
  - On consume with no ack: clear if_valid.
- HOLD state:
  - imem_req=0.
  - When slot_free: move skid into the output register (if_valid=1); go to FETCH.
- DRAIN state:
  - imem_req=1, imem_addr=old address, kept stable; pc holds the redirect target.
  - On ack: drop the data and go to FETCH.
  - if_valid=0 throughout DRAIN.
- Redirect has highest priority. At an edge with redirect=1:
  - if_valid is cleared and the skid is discarded.
  - If in FETCH with no ack this edge: the old address is kept for the outstanding request, the target is saved (pc<=redirect_pc), and the state goes to DRAIN.
  - Otherwise (ack this edge, or in HOLD or DRAIN): pc<=redirect_pc. The state goes to FETCH, except DRAIN with no ack, which stays in DRAIN with the target updated.
  - A consume in the same cycle is irrelevant because the output is flushed.
- Latency and throughput: with single-cycle ack, if_valid rises one cycle after the ack edge. Sustained throughput is one instruction per clock.
- Arithmetic: pc wraps modulo 2^ADDR_W (0xFFFE+2 -> 0x0000). redirect_pc is used unaltered; bit 0 is not masked.
- opCode is combinational from the output register. 4'b0000 (jump encoding with no register or memory write) is presented while if_valid=0.
- Ordering: instructions leave in fetch order, with no loss or duplication outside redirect flushes.

Test Plan:
1. Reset, then ack every cycle with rdata = 0xF123, 0x8456, 0x9789, stall=0 -> if_pc = 0x0000, 0x0002, 0x0004 on consecutive cycles; opCode = F, 8, 9; if_valid rises one cycle after the first ack.
2. Assert stall for 3 cycles while acks continue -> if_instr is held, one more instruction is captured in the skid, imem_req drops; after stall release, both drain in order and fetch resumes at the next pc with no drop or duplicate.
3. Redirect to 0x0040 while in FETCH with ack delayed 3 cycles -> imem_addr stays at the old value until the ack, that data is discarded, then imem_addr=0x0040; if_valid stays 0 in between.
4. Redirect to 0x0100 in the same cycle as an ack and a consume -> output flushed, the acked instruction is never presented, next request is at 0x0100.
5. RESET_PC=0xFFFE, ack continuously -> if_pc sequence 0xFFFE, 0x0000, 0x0002.
6. rst asserted while in HOLD with stall=1 -> next cycle if_valid=0, opCode=0000, pc=RESET_PC; the cycle after rst deasserts, imem_req=1 at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// PC owner and imem requester feeding the decoder through a one-entry output register with a skid entry.
// Output appears one cycle after the ack edge; a stalled ack parks in the skid and pauses requests until drained.
module fetch_stage #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 2
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [3:0]         opCode
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  opc_q, opc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

  logic slot_free;
  logic ack;
  logic [ADDR_W-1:0] pc_inc;

  assign slot_free = ~vld_q | ~stall;
  assign ack       = imem.imem_ack;
  assign pc_inc    = pc_q + ADDR_W'(PC_INC);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      if ((state_q == FETCH || state_q == DRAIN) && !ack) state_d = DRAIN;
      else                                                state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:   if (ack && !slot_free) state_d = HOLD;
        HOLD:    if (slot_free)         state_d = FETCH;
        DRAIN:   if (ack)               state_d = FETCH;
        default:                        state_d = FETCH;
      endcase
    end
  end

  // FSM outputs; DRAIN keeps presenting the abandoned address until its ack returns
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    if (!rst) begin
      case (state_q)
        FETCH:   imem.imem_req = 1'b1;
        DRAIN: begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = drain_addr_q;
        end
        default: imem.imem_req = 1'b0;
      endcase
    end
  end

  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    vld_d        = vld_q;
    instr_d      = instr_q;
    opc_d        = opc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (redirect) begin
      vld_d = 1'b0;
      pc_d  = redirect_pc;
      if (state_q == FETCH && !ack) drain_addr_d = pc_q;
    end else begin
      case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = pc_inc;
            if (slot_free) begin
              vld_d   = 1'b1;
              instr_d = imem.imem_rdata;
              opc_d   = pc_q;
            end else begin
              skid_instr_d = imem.imem_rdata;
              skid_pc_d    = pc_q;
            end
          end else if (vld_q && !stall) begin
            vld_d = 1'b0;
          end
        end
        HOLD: begin
          if (slot_free) begin
            vld_d   = 1'b1;
            instr_d = skid_instr_q;
            opc_d   = skid_pc_q;
          end
        end
        default: vld_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      vld_q        <= 1'b0;
      instr_q      <= '0;
      opc_q        <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      vld_q        <= vld_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign if_valid = vld_q;
  assign if_instr = instr_q;
  assign if_pc    = opc_q;
  assign opCode   = vld_q ? instr_q[INSTR_W-1 -: 4] : 4'b0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed checks of fetch_stage; a second instance with RESET_PC=0xFFFE covers PC wrap.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_valid, if_valid2;
  logic [15:0] if_instr, if_instr2;
  logic [15:0] if_pc, if_pc2;
  logic [3:0]  opCode, opCode2;

  int checks = 0;
  int errors = 0;

  fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) mif ();
  fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) mif2 ();

  fetch_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_INC(2)) dut (
    .clk(clk), .rst(rst), .imem(mif.master), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .opCode(opCode)
  );

  fetch_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE), .PC_INC(2)) dut_wrap (
    .clk(clk), .rst(rst), .imem(mif2.master), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
    .opCode(opCode2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mif.imem_ack = 1'b0; mif.imem_rdata = 16'h0000;
    mif2.imem_ack = 1'b1; mif2.imem_rdata = 16'hA000;
    tick(); tick();
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_opcode", {28'b0, opCode}, 32'h0);
    chk("rst_req", {31'b0, mif.imem_req}, 32'h0);
    chk("rst_pc", {16'b0, if_pc}, 32'h0);
    chk("rst_instr", {16'b0, if_instr}, 32'h0);

    // Test 1 / 5: back-to-back acks, and the wrapping instance in parallel
    rst = 1'b0; mif.imem_ack = 1'b1; mif.imem_rdata = 16'hF123;
    #1;
    chk("t1_req", {31'b0, mif.imem_req}, 32'h1);
    chk("t1_addr0", {16'b0, mif.imem_addr}, 32'h0000);
    chk("t1_valid_pre", {31'b0, if_valid}, 32'h0);
    chk("t5_addr0", {16'b0, mif2.imem_addr}, 32'hFFFE);
    tick();
    chk("t1_valid", {31'b0, if_valid}, 32'h1);
    chk("t1_pc0", {16'b0, if_pc}, 32'h0000);
    chk("t1_instr0", {16'b0, if_instr}, 32'hF123);
    chk("t1_op0", {28'b0, opCode}, 32'hF);
    chk("t1_addr1", {16'b0, mif.imem_addr}, 32'h0002);
    chk("t5_pc0", {16'b0, if_pc2}, 32'hFFFE);
    mif.imem_rdata = 16'h8456;
    tick();
    chk("t1_pc1", {16'b0, if_pc}, 32'h0002);
    chk("t1_op1", {28'b0, opCode}, 32'h8);
    chk("t5_pc1", {16'b0, if_pc2}, 32'h0000);
    mif.imem_rdata = 16'h9789;
    tick();
    chk("t1_pc2", {16'b0, if_pc}, 32'h0004);
    chk("t1_op2", {28'b0, opCode}, 32'h9);
    chk("t5_pc2", {16'b0, if_pc2}, 32'h0002);
    chk("t5_valid", {31'b0, if_valid2}, 32'h1);

    // Test 2: stall three cycles; one ack lands in the skid
    stall = 1'b1; mif.imem_rdata = 16'hA111;
    tick();
    chk("t2_hold_instr", {16'b0, if_instr}, 32'h9789);
    chk("t2_req_drop", {31'b0, mif.imem_req}, 32'h0);
    mif.imem_ack = 1'b0;
    tick();
    chk("t2_hold_instr2", {16'b0, if_instr}, 32'h9789);
    chk("t2_req_drop2", {31'b0, mif.imem_req}, 32'h0);
    tick();
    chk("t2_hold_pc", {16'b0, if_pc}, 32'h0004);
    chk("t2_hold_valid", {31'b0, if_valid}, 32'h1);
    stall = 1'b0;
    tick();
    chk("t2_skid_instr", {16'b0, if_instr}, 32'hA111);
    chk("t2_skid_pc", {16'b0, if_pc}, 32'h0006);
    chk("t2_req_resume", {31'b0, mif.imem_req}, 32'h1);
    chk("t2_addr_resume", {16'b0, mif.imem_addr}, 32'h0008);
    mif.imem_ack = 1'b1; mif.imem_rdata = 16'hB222;
    tick();
    chk("t2_next_pc", {16'b0, if_pc}, 32'h0008);
    chk("t2_next_instr", {16'b0, if_instr}, 32'hB222);

    // Test 3: redirect with the outstanding request acked three cycles later
    mif.imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("t3_addr_old0", {16'b0, mif.imem_addr}, 32'h000A);
    chk("t3_req", {31'b0, mif.imem_req}, 32'h1);
    chk("t3_valid0", {31'b0, if_valid}, 32'h0);
    chk("t3_op0", {28'b0, opCode}, 32'h0);
    tick();
    chk("t3_addr_old1", {16'b0, mif.imem_addr}, 32'h000A);
    chk("t3_valid1", {31'b0, if_valid}, 32'h0);
    tick();
    chk("t3_addr_old2", {16'b0, mif.imem_addr}, 32'h000A);
    mif.imem_ack = 1'b1; mif.imem_rdata = 16'hC333;
    tick();
    chk("t3_dropped", {31'b0, if_valid}, 32'h0);
    chk("t3_addr_new", {16'b0, mif.imem_addr}, 32'h0040);
    mif.imem_rdata = 16'hD444;
    tick();
    chk("t3_pc", {16'b0, if_pc}, 32'h0040);
    chk("t3_instr", {16'b0, if_instr}, 32'hD444);

    // Test 4: redirect coinciding with ack and consume
    mif.imem_rdata = 16'hE555; redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    chk("t4_flush", {31'b0, if_valid}, 32'h0);
    chk("t4_addr", {16'b0, mif.imem_addr}, 32'h0100);
    chk("t4_req", {31'b0, mif.imem_req}, 32'h1);
    mif.imem_rdata = 16'h1666;
    tick();
    chk("t4_pc", {16'b0, if_pc}, 32'h0100);
    chk("t4_instr", {16'b0, if_instr}, 32'h1666);

    // Test 6: reset while parked in HOLD
    stall = 1'b1; mif.imem_rdata = 16'h2777;
    tick();
    chk("t6_hold_req", {31'b0, mif.imem_req}, 32'h0);
    chk("t6_hold_valid", {31'b0, if_valid}, 32'h1);
    rst = 1'b1; mif.imem_ack = 1'b0;
    tick();
    chk("t6_valid", {31'b0, if_valid}, 32'h0);
    chk("t6_op", {28'b0, opCode}, 32'h0);
    chk("t6_req_forced", {31'b0, mif.imem_req}, 32'h0);
    chk("t6_wrap_req_forced", {31'b0, mif2.imem_req}, 32'h0);
    rst = 1'b0; stall = 1'b0;
    #1;
    chk("t6_req", {31'b0, mif.imem_req}, 32'h1);
    chk("t6_addr", {16'b0, mif.imem_addr}, 32'h0000);
    mif.imem_ack = 1'b1; mif.imem_rdata = 16'h3888;
    tick();
    chk("t6_pc_after", {16'b0, if_pc}, 32'h0000);
    chk("t6_instr_after", {16'b0, if_instr}, 32'h3888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
